// File: rtl/d3_pkg.sv
// Shared types and constants for the d3 descrambler/deframer.
// Latency: n/a (package only).
// Backpressure: n/a.
package d3_pkg;

    // Framing state: hunting for the sync word, or locked to frame boundaries.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Feed-forward taps of the descrambler: d[n] = r[n] ^ r[n-2] ^ r[n-3].
    localparam int D3_TAP_A = 2;
    localparam int D3_TAP_B = 3;

    // Default frame header pattern.
    localparam logic [7:0] D3_SYNC_DEFAULT = 8'hA5;

    // Next word slot inside a frame; slot 0 is the sync word.
    function automatic int d3_next_idx(input int idx, input int frame_words);
        return (idx >= frame_words - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/d3_descrambler.sv
// Self-synchronising descrambler: 3-bit raw-bit history XORed with the live bit.
// Latency: descr_o is combinational from bit_i; history updates on valid edges.
// Backpressure: none; history only advances when vld_i is high.
module d3_descrambler
    import d3_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic bit_i,
    input  logic vld_i,
    output logic descr_o
);

    // hist_q[0] = r[n-1], hist_q[1] = r[n-2], hist_q[2] = r[n-3]
    logic [2:0] hist_q;
    logic [2:0] hist_d;

    // Undo the scrambler recursion using the raw received bits only.
    always_comb begin
        descr_o = bit_i ^ hist_q[D3_TAP_A-1] ^ hist_q[D3_TAP_B-1];
    end

    // Shift the raw bit into the history only on valid edges.
    always_comb begin
        hist_d = hist_q;
        if (vld_i) begin
            hist_d = {hist_q[1:0], bit_i};
        end
    end

    // History register, cleared on reset so a zero-seeded scrambler decodes from bit 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= 3'b000;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/d3_descrambler_deframer.sv
// Descrambles a serial bit stream, hunts for the sync word and deserializes frame payload words.
// Latency: byte_vld is high the cycle right after the edge that captured a word's last bit.
// Backpressure: none; the consumer must accept every byte_vld pulse, input advances on bit_vld.
module d3_descrambler_deframer
    import d3_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(D3_SYNC_DEFAULT),
    parameter int               FRAME_BYTES = 4,
    parameter int               MISS_MAX    = 2
) (
    input  logic             d_clk,
    input  logic             d_rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [WIDTH-1:0] byte_out,
    output logic             byte_vld,
    output logic             byte_sof,
    output logic             locked,
    output logic             sync_err
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int IDX_W  = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam int FILL_W = $clog2(WIDTH + 4);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH + 3);
    localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);

    logic descr;
    logic [WIDTH-1:0] word;

    state_e            state_q,    state_d;
    logic [WIDTH-2:0]  shreg_q,    shreg_d;
    logic [FILL_W-1:0] fill_q,     fill_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [MISS_W-1:0] miss_inc;
    logic [WIDTH-1:0]  byte_out_q, byte_out_d;
    logic              byte_vld_q, byte_vld_d;
    logic              byte_sof_q, byte_sof_d;
    logic              locked_q,   locked_d;
    logic              sync_err_q, sync_err_d;

    d3_descrambler u_descr (
        .clk_i   (d_clk),
        .rst_n_i (d_rst_n),
        .bit_i   (bit_in),
        .vld_i   (bit_vld),
        .descr_o (descr)
    );

    // Candidate word: the last WIDTH descrambled bits including the one arriving now.
    always_comb begin
        word     = {shreg_q, descr};
        miss_inc = miss_cnt_q + MISS_W'(1);
    end

    // Framing FSM and deserializer next-state; pulses default low every edge.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        fill_d     = fill_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        miss_cnt_d = miss_cnt_q;
        byte_out_d = byte_out_q;
        locked_d   = locked_q;
        byte_vld_d = 1'b0;
        byte_sof_d = 1'b0;
        sync_err_d = 1'b0;

        if (bit_vld) begin
            shreg_d = word[WIDTH-2:0];
            // The first few descrambled bits are garbage, so hunting waits
            // until a full window of self-synchronised bits is available.
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end

            case (state_q)
                HUNT: begin
                    if ((fill_q == FILL_MAX) && (word == SYNC_WORD)) begin
                        state_d    = LOCKED;
                        locked_d   = 1'b1;
                        bit_cnt_d  = '0;
                        word_idx_d = IDX_W'(1);
                        miss_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d  = '0;
                        word_idx_d = IDX_W'(d3_next_idx(int'(word_idx_q), FRAME_BYTES));
                        if (word_idx_q != '0) begin
                            byte_out_d = word;
                            byte_vld_d = 1'b1;
                            byte_sof_d = (word_idx_q == IDX_W'(1));
                        end else if (word == SYNC_WORD) begin
                            miss_cnt_d = '0;
                        end else begin
                            // Flywheel through isolated misses; only a run of
                            // MISS_MAX consecutive misses drops lock.
                            sync_err_d = 1'b1;
                            miss_cnt_d = miss_inc;
                            if (miss_inc == MISS_LIM) begin
                                state_d  = HUNT;
                                locked_d = 1'b0;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge d_clk or negedge d_rst_n) begin
        if (!d_rst_n) begin
            state_q    <= HUNT;
            shreg_q    <= '0;
            fill_q     <= '0;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            miss_cnt_q <= '0;
            byte_out_q <= '0;
            byte_vld_q <= 1'b0;
            byte_sof_q <= 1'b0;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            fill_q     <= fill_d;
            bit_cnt_q  <= bit_cnt_d;
            word_idx_q <= word_idx_d;
            miss_cnt_q <= miss_cnt_d;
            byte_out_q <= byte_out_d;
            byte_vld_q <= byte_vld_d;
            byte_sof_q <= byte_sof_d;
            locked_q   <= locked_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Drive ports from the registers.
    always_comb begin
        byte_out = byte_out_q;
        byte_vld = byte_vld_q;
        byte_sof = byte_sof_q;
        locked   = locked_q;
        sync_err = sync_err_q;
    end

endmodule

// File: tb/tb_d3_descrambler_deframer.sv
// Directed bench: zero-seeded scrambler model feeds the DUT, expected payload words go through a queue.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_d3_descrambler_deframer;

    localparam int K_NONE = 0;
    localparam int K_LOCK = 1;
    localparam int K_PAY  = 2;
    localparam int K_SYNC = 3;
    localparam int K_ERR  = 4;
    localparam int K_DROP = 5;

    logic       d_clk   = 1'b0;
    logic       d_rst_n = 1'b0;
    logic       bit_in  = 1'b0;
    logic       bit_vld = 1'b0;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       byte_sof;
    logic       locked;
    logic       sync_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic [2:0] sh = 3'b000;
    bit   gap = 1'b0;
    logic exp_locked = 1'b0;

    typedef struct packed {
        logic       sof;
        logic [7:0] dat;
    } exp_t;
    exp_t sb[$];

    d3_descrambler_deframer #(
        .WIDTH       (8),
        .SYNC_WORD   (8'hA5),
        .FRAME_BYTES (4),
        .MISS_MAX    (2)
    ) dut (
        .d_clk    (d_clk),
        .d_rst_n  (d_rst_n),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .byte_out (byte_out),
        .byte_vld (byte_vld),
        .byte_sof (byte_sof),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 d_clk = ~d_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One raw channel bit; checks outputs after the edge, and in the idle gap cycle if enabled.
    task automatic send_bit(input logic b, input logic exp_v, input logic exp_e);
        exp_t e;
        bit_in  = b;
        bit_vld = 1'b1;
        @(posedge d_clk);
        #1;
        bit_vld = 1'b0;
        bit_in  = 1'b0;
        check("locked", locked, exp_locked);
        check("byte_vld", byte_vld, exp_v);
        check("sync_err", sync_err, exp_e);
        if (byte_vld) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("byte_out", byte_out, e.dat);
                check("byte_sof", byte_sof, e.sof);
            end
        end
        if (gap) begin
            @(posedge d_clk);
            #1;
            check("gap_vld", byte_vld, 1'b0);
            check("gap_err", sync_err, 1'b0);
        end
    endtask

    // Scrambler model: s[n] = d[n] ^ s[n-2] ^ s[n-3]; flip models a channel error.
    task automatic send_data_bit(input logic d, input logic flip, input logic exp_v, input logic exp_e);
        logic s;
        s  = d ^ sh[1] ^ sh[2];
        sh = {sh[1:0], s};
        send_bit(s ^ flip, exp_v, exp_e);
    endtask

    task automatic send_word(input logic [7:0] data, input int kind, input logic sof,
                             input logic [7:0] exp_dat, input int flip_pos);
        exp_t e;
        logic last;
        for (int i = 0; i < 8; i++) begin
            last = (i == 7);
            if (last) begin
                if (kind == K_PAY) begin
                    e.sof = sof;
                    e.dat = exp_dat;
                    sb.push_back(e);
                end
                if (kind == K_LOCK) exp_locked = 1'b1;
                if (kind == K_DROP) exp_locked = 1'b0;
            end
            send_data_bit(data[7-i], (i == flip_pos),
                          last && (kind == K_PAY),
                          last && ((kind == K_ERR) || (kind == K_DROP)));
        end
    endtask

    task automatic pay(input logic [7:0] d, input logic sof);
        send_word(d, K_PAY, sof, d, -1);
    endtask

    task automatic ctl(input logic [7:0] d, input int kind);
        send_word(d, kind, 1'b0, 8'h00, -1);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) send_data_bit(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bit_vld    = 1'b0;
        d_rst_n    = 1'b0;
        sh         = 3'b000;
        exp_locked = 1'b0;
        sb.delete();
        repeat (2) @(posedge d_clk);
        #1;
        d_rst_n = 1'b1;
    endtask

    task automatic lock_up();
        zeros(16);
        ctl(8'hA5, K_LOCK);
    endtask

    task automatic basic_stream();
        lock_up();
        pay(8'h11, 1'b1); pay(8'h22, 1'b0); pay(8'h33, 1'b0);
        ctl(8'hA5, K_SYNC);
        pay(8'h44, 1'b1); pay(8'h55, 1'b0); pay(8'h66, 1'b0);
        check("sb_drain", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] w22;

        // Reset holds every output low even with toggling valid input.
        d_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_in  = i[0];
            bit_vld = 1'b1;
            @(posedge d_clk);
            #1;
            check("rst_outs", {byte_out, byte_vld, byte_sof, locked, sync_err}, 12'h000);
        end
        bit_vld = 1'b0;
        bit_in  = 1'b0;
        d_rst_n = 1'b1;
        zeros(10);

        // Basic lock, back-to-back bits.
        do_reset();
        gap = 1'b0;
        basic_stream();

        // Same stream with bit_vld low on alternate cycles.
        do_reset();
        gap = 1'b1;
        basic_stream();
        gap = 1'b0;

        // Single miss: flywheel keeps lock and payload; a match clears the count.
        do_reset();
        lock_up();
        pay(8'h11, 1'b1); pay(8'h22, 1'b0); pay(8'h33, 1'b0);
        ctl(8'hA5, K_SYNC);
        pay(8'h44, 1'b1); pay(8'h55, 1'b0); pay(8'h66, 1'b0);
        ctl(8'hA4, K_ERR);
        pay(8'h77, 1'b1); pay(8'h88, 1'b0); pay(8'h99, 1'b0);
        ctl(8'hA5, K_SYNC);
        pay(8'hAA, 1'b1); pay(8'hBB, 1'b0); pay(8'hCC, 1'b0);
        ctl(8'hA4, K_ERR);
        pay(8'hDD, 1'b1); pay(8'hEE, 1'b0); pay(8'hFF, 1'b0);
        check("sb_drain_miss1", sb.size(), 0);

        // Two consecutive misses drop lock; silent until the next sync relocks.
        do_reset();
        lock_up();
        pay(8'h11, 1'b1); pay(8'h22, 1'b0); pay(8'h33, 1'b0);
        ctl(8'hA5, K_SYNC);
        pay(8'h44, 1'b1); pay(8'h55, 1'b0); pay(8'h66, 1'b0);
        ctl(8'hA4, K_ERR);
        pay(8'h77, 1'b1); pay(8'h88, 1'b0); pay(8'h99, 1'b0);
        ctl(8'hA4, K_DROP);
        ctl(8'h00, K_NONE); ctl(8'h00, K_NONE); ctl(8'h00, K_NONE);
        ctl(8'hA5, K_LOCK);
        pay(8'h11, 1'b1); pay(8'h22, 1'b0); pay(8'h33, 1'b0);
        check("sb_drain_miss2", sb.size(), 0);

        // One channel bit error at position 2 of 0x22 corrupts positions 2, 4, 5.
        do_reset();
        lock_up();
        pay(8'h11, 1'b1);
        send_word(8'h22, K_PAY, 1'b0, 8'h22 ^ 8'h2C, 2);
        pay(8'h33, 1'b0);
        ctl(8'hA5, K_SYNC);
        pay(8'h44, 1'b1); pay(8'h55, 1'b0); pay(8'h66, 1'b0);
        check("sb_drain_err", sb.size(), 0);

        // Reset in the middle of a payload word; relock needs warm-up plus sync.
        do_reset();
        lock_up();
        pay(8'h11, 1'b1);
        w22 = 8'h22;
        for (int i = 0; i < 3; i++) send_data_bit(w22[7-i], 1'b0, 1'b0, 1'b0);
        d_rst_n = 1'b0;
        #1;
        check("midrst_outs", {byte_out, byte_vld, byte_sof, locked, sync_err}, 12'h000);
        sh         = 3'b000;
        exp_locked = 1'b0;
        sb.delete();
        repeat (2) @(posedge d_clk);
        #1;
        d_rst_n = 1'b1;
        ctl(8'hA5, K_NONE);
        ctl(8'h00, K_NONE);
        ctl(8'hA5, K_LOCK);
        pay(8'h11, 1'b1); pay(8'h22, 1'b0); pay(8'h33, 1'b0);
        check("sb_drain_rst", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
